// File: rtl/contatore_mod_updown.sv
// Modulo-MOD up/down counter with synchronous load, variable step and wrap/saturate
// mode. Exposes the registered count, the combinational next count, tc and a sticky ovf flag.
module contatore_mod_updown #(
    parameter int N      = 4,
    parameter int MOD    = 10,
    parameter int STEP_W = 2,
    parameter int SAT    = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    input  logic              load,
    input  logic [N-1:0]      load_val,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic              clr_ovf,
    output logic [N-1:0]      count_q,
    output logic [N-1:0]      count_next,
    output logic              tc,
    output logic              ovf_sticky
);

    generate
        if (MOD < 2 || MOD > (1 << N)) begin : g_bad_mod
            $error("contatore_mod_updown: MOD must lie in 2..2^N");
        end
        if (((1 << STEP_W) - 1) >= MOD) begin : g_bad_step
            $error("contatore_mod_updown: 2^STEP_W-1 must be smaller than MOD");
        end
    endgenerate

    // The modulus may equal 2^N, so it only fits in N+1 bits.
    localparam logic [N:0]   MOD_W   = (N+1)'(MOD);
    localparam logic [N-1:0] MAX_CNT = N'(MOD - 1);

    logic [N:0] ext_q;
    logic [N:0] ext_step;
    logic [N:0] sum;

    assign ext_q    = {1'b0, count_q};
    assign ext_step = (N+1)'(step);
    assign sum      = ext_q + ext_step;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        count_next = count_q;
        tc         = 1'b0;
        if (!reset_n) begin
            count_next = '0;
        end else if (load) begin
            count_next = ({1'b0, load_val} < MOD_W) ? load_val : MAX_CNT;
        end else if (en) begin
            if (up) begin
                if (sum < MOD_W) begin
                    count_next = sum[N-1:0];
                end else begin
                    tc         = 1'b1;
                    count_next = (SAT != 0) ? MAX_CNT : N'(sum - MOD_W);
                end
            end else begin
                if (ext_q >= ext_step) begin
                    count_next = N'(ext_q - ext_step);
                end else begin
                    tc         = 1'b1;
                    count_next = (SAT != 0) ? '0 : N'(ext_q + MOD_W - ext_step);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            count_q <= count_next;
            if (tc) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_contatore_mod_updown.sv
// Self-checking bench for contatore_mod_updown: one wrapping and one saturating
// instance (N=4, MOD=10, STEP_W=2), table-driven vectors plus a reset sequence.
module tb_contatore_mod_updown;

    typedef struct packed {
        logic       en;
        logic       load;
        logic [3:0] load_val;
        logic       up;
        logic [1:0] step;
        logic       clr_ovf;
    } in_t;

    typedef struct {
        bit         sat;
        in_t        in;
        logic [3:0] e_next;
        logic       e_tc;
        logic       e_ovf;
    } vec_t;

    typedef struct {
        bit         sat;
        logic [3:0] e_q;
        logic       e_ovf;
    } sb_t;

    localparam in_t IDLE = '0;

    logic       clock;
    logic       reset_n;
    in_t        in_a, in_b;
    logic [3:0] a_q, a_next, b_q, b_next;
    logic       a_tc, a_ovf, b_tc, b_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    contatore_mod_updown #(.N(4), .MOD(10), .STEP_W(2), .SAT(0)) dut_wrap (
        .clock(clock), .reset_n(reset_n), .en(in_a.en), .load(in_a.load),
        .load_val(in_a.load_val), .up(in_a.up), .step(in_a.step), .clr_ovf(in_a.clr_ovf),
        .count_q(a_q), .count_next(a_next), .tc(a_tc), .ovf_sticky(a_ovf)
    );

    contatore_mod_updown #(.N(4), .MOD(10), .STEP_W(2), .SAT(1)) dut_sat (
        .clock(clock), .reset_n(reset_n), .en(in_b.en), .load(in_b.load),
        .load_val(in_b.load_val), .up(in_b.up), .step(in_b.step), .clr_ovf(in_b.clr_ovf),
        .count_q(b_q), .count_next(b_next), .tc(b_tc), .ovf_sticky(b_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit sat, bit ld, int lv, bit en, bit up, int st, bit clr,
                                int e_next, bit e_tc, bit e_ovf);
        vec_t v;
        v.sat         = sat;
        v.in.load     = ld;
        v.in.load_val = 4'(lv);
        v.in.en       = en;
        v.in.up       = up;
        v.in.step     = 2'(st);
        v.in.clr_ovf  = clr;
        v.e_next      = 4'(e_next);
        v.e_tc        = e_tc;
        v.e_ovf       = e_ovf;
        return v;
    endfunction

    // Drive one vector, check the Mealy outputs in-cycle, then the registered
    // outputs one edge later through the scoreboard queue.
    task automatic run_vec(input vec_t v, input string name);
        sb_t e;
        if (v.sat) begin
            in_b = v.in;
            in_a = IDLE;
        end else begin
            in_a = v.in;
            in_b = IDLE;
        end
        #1;
        check({name, ".count_next"}, v.sat ? b_next : a_next, v.e_next);
        check({name, ".tc"}, v.sat ? b_tc : a_tc, v.e_tc);
        sb.push_back('{sat: v.sat, e_q: v.e_next, e_ovf: v.e_ovf});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({name, ".count_q"}, e.sat ? b_q : a_q, e.e_q);
        check({name, ".ovf_sticky"}, e.sat ? b_ovf : a_ovf, e.e_ovf);
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        in_a    = IDLE;
        in_b    = IDLE;
        repeat (2) @(negedge clock);
        check("rst.count_q", a_q, 0);
        check("rst.ovf", a_ovf, 0);
        check("rst.count_next", a_next, 0);
        check("rst.sat_count_q", b_q, 0);
        reset_n = 1'b1;

        // Bring wrap counter to 7 with ovf set, then hit it with an async reset.
        run_vec(mk(0, 1, 9, 0, 0, 0, 0, 9, 0, 0), "pre0");
        run_vec(mk(0, 0, 0, 1, 1, 3, 0, 2, 1, 1), "pre1");
        run_vec(mk(0, 1, 7, 0, 0, 0, 0, 7, 0, 1), "pre2");
        in_a.en   = 1'b1;
        in_a.up   = 1'b1;
        in_a.step = 2'd3;
        #2 reset_n = 1'b0;
        #1;
        check("async_rst.count_q", a_q, 0);
        check("async_rst.ovf", a_ovf, 0);
        check("async_rst.count_next", a_next, 0);
        check("async_rst.tc", a_tc, 0);
        @(negedge clock);
        in_a    = IDLE;
        reset_n = 1'b1;

        // wrap mode: up by 3 from 0
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 9, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 2, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 2, 0, 0));
        // wrap mode: down by 2 from 1
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 9, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 2, 0, 7, 0, 1));
        // load priority over en, clamp of out-of-range load_val
        vecs.push_back(mk(0, 1, 12, 1, 1, 3, 0, 9, 0, 1));
        vecs.push_back(mk(0, 1, 4, 1, 1, 3, 0, 4, 0, 1));
        // sticky flag: set wins over clear, then clear alone
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 4, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 7, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 0, 0, 0));
        // hold with en=0, step=0, and a down wrap from 0
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 7, 1, 1));
        // saturate mode
        vecs.push_back(mk(1, 1, 8, 0, 0, 0, 0, 8, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 9, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 9, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 0, 9, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 2, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 2, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 10, 0, 0, 0, 0, 9, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 9, 1, 1));

        for (int k = 0; k < vecs.size(); k++) begin
            run_vec(vecs[k], $sformatf("v%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
